// File: rtl/nvme_action_cmd_master.sv
// Action-side NVMe command sequencer: six AXI-Lite register writes, then STATUS polling, then one response beat.
// One AXI transaction in flight at a time; cmd is accepted only in IDLE, and rsp is held stable until rsp_ready.
`ifndef HOST_ADDR_BITS
`define HOST_ADDR_BITS 32
`endif

module nvme_action_cmd_master #(
    parameter int                        HOST_ADDR_BITS = `HOST_ADDR_BITS,
    parameter logic [HOST_ADDR_BITS-1:0] REG_BASE       = '0,
    parameter int                        POLL_GAP       = 16,
    parameter int                        POLL_MAX       = 65535
) (
    input  logic                      axi_aclk,
    input  logic                      axi_aresetn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic                      cmd_drive,
    input  logic [63:0]               cmd_lba,
    input  logic [15:0]               cmd_nblocks,
    input  logic [63:0]               cmd_addr,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [15:0]               rsp_status,
    output logic [1:0]                rsp_error,
    output logic [HOST_ADDR_BITS-1:0] m_axi_awaddr,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [31:0]               m_axi_wdata,
    output logic [3:0]                m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [HOST_ADDR_BITS-1:0] m_axi_araddr,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [31:0]               m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WRESP, S_GAP, S_RD, S_RRESP, S_RSP} state_t;

    localparam logic [HOST_ADDR_BITS-1:0] STATUS_ADDR = REG_BASE + HOST_ADDR_BITS'(32'h18);

    state_t      state, state_nx;
    logic [2:0]  widx;
    logic        aw_done, w_done;
    logic [15:0] gap_cnt, poll_cnt;
    logic        write_q, drive_q;
    logic [63:0] lba_q, addr_q;
    logic [15:0] nblocks_q;
    logic [31:0] word;
    logic        unused_bits;

    assign unused_bits = ^m_axi_rdata[30:16];
    assign m_axi_wstrb = 4'hF;

    always_comb begin
        word = '0;
        case (widx)
            3'd0:    word = addr_q[31:0];
            3'd1:    word = addr_q[63:32];
            3'd2:    word = lba_q[31:0];
            3'd3:    word = lba_q[63:32];
            3'd4:    word = {16'b0, nblocks_q};
            3'd5:    word = {29'b0, drive_q, write_q, 1'b1};
            default: word = '0;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) state <= S_IDLE;
        else              state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_awaddr  = '0;
        m_axi_wdata   = '0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_araddr  = '0;
        m_axi_rready  = 1'b0;
        rsp_valid     = 1'b0;
        case (state)
            S_IDLE: if (cmd_valid && cmd_ready) state_nx = S_WR;
            S_WR: begin
                m_axi_awvalid = !aw_done;
                m_axi_wvalid  = !w_done;
                m_axi_awaddr  = REG_BASE + HOST_ADDR_BITS'({widx, 2'b00});
                m_axi_wdata   = word;
                if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_nx = S_WRESP;
            end
            S_WRESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) state_nx = S_RSP;
                    else if (widx == 3'd5)    state_nx = S_GAP;
                    else                      state_nx = S_WR;
                end
            end
            S_GAP: if (gap_cnt == 16'(POLL_GAP - 1)) state_nx = S_RD;
            S_RD: begin
                m_axi_arvalid = 1'b1;
                m_axi_araddr  = STATUS_ADDR;
                if (m_axi_arready) state_nx = S_RRESP;
            end
            S_RRESP: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) begin
                    if (m_axi_rresp != 2'b00 || m_axi_rdata[31] || poll_cnt == 16'(POLL_MAX))
                        state_nx = S_RSP;
                    else
                        state_nx = S_GAP;
                end
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            cmd_ready  <= 1'b0;
            widx       <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            gap_cnt    <= '0;
            poll_cnt   <= '0;
            write_q    <= 1'b0;
            drive_q    <= 1'b0;
            lba_q      <= '0;
            addr_q     <= '0;
            nblocks_q  <= '0;
            rsp_status <= '0;
            rsp_error  <= '0;
        end else begin
            cmd_ready <= (state_nx == S_IDLE);
            // done flags live only while the current word is still in WR
            aw_done   <= (state_nx == S_WR) && (aw_done || (state == S_WR && m_axi_awready));
            w_done    <= (state_nx == S_WR) && (w_done || (state == S_WR && m_axi_wready));
            gap_cnt   <= (state == S_GAP) ? gap_cnt + 16'd1 : 16'd0;
            case (state)
                S_IDLE: if (cmd_valid && cmd_ready) begin
                    write_q   <= cmd_write;
                    drive_q   <= cmd_drive;
                    lba_q     <= cmd_lba;
                    nblocks_q <= cmd_nblocks;
                    addr_q    <= cmd_addr;
                    widx      <= '0;
                end
                S_WRESP: if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        rsp_error  <= 2'd2;
                        rsp_status <= {14'b0, m_axi_bresp};
                    end else if (widx == 3'd5) begin
                        poll_cnt <= '0;
                    end else begin
                        widx <= widx + 3'd1;
                    end
                end
                S_RD: if (m_axi_arready) poll_cnt <= poll_cnt + 16'd1;
                S_RRESP: if (m_axi_rvalid) begin
                    // AXI error outranks the done bit, which outranks the timeout
                    if (m_axi_rresp != 2'b00) begin
                        rsp_error  <= 2'd2;
                        rsp_status <= {14'b0, m_axi_rresp};
                    end else if (m_axi_rdata[31]) begin
                        rsp_status <= m_axi_rdata[15:0];
                        rsp_error  <= (m_axi_rdata[15:0] != 16'h0) ? 2'd1 : 2'd0;
                    end else if (poll_cnt == 16'(POLL_MAX)) begin
                        rsp_error  <= 2'd3;
                        rsp_status <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
